// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: requests a byte from program memory, holds it
// for the decoder, then strobes the next PC (sequential or branch target).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no fetch in flight; waits for en_fetch (blocked once err is set)
// REQ   | mem_req high at a fixed mem_adrs, waiting for mem_ack or timeout
// HOLD  | instr valid, waiting for the decoder to take it
// UPD   | one-cycle en_pc pulse loading nxt_adrs into the pc register
module fetch_ctrl (
    input  logic       clk,
    input  logic       clr,
    input  logic       en_fetch,
    input  logic [7:0] pc_adrs,
    output logic [7:0] nxt_adrs,
    output logic       en_pc,
    output logic       mem_req,
    output logic [7:0] mem_adrs,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic [7:0] instr,
    output logic       instr_vld,
    input  logic       instr_take,
    input  logic       br_take,
    input  logic [7:0] br_adrs,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        UPD  = 2'd3
    } state_t;

    // The counter moves 0..14 over the first 15 unacknowledged REQ cycles;
    // the 15th one without ack takes it to 15 and aborts the fetch.
    localparam logic [3:0] WAIT_LAST = 4'd14;

    state_t     state_q;
    logic [3:0] wait_q;
    logic [7:0] nxt_adrs_q;
    logic       en_pc_q;
    logic       mem_req_q;
    logic [7:0] mem_adrs_q;
    logic [7:0] instr_q;
    logic       instr_vld_q;
    logic       err_q;
    logic [7:0] nxt_adrs_d;

    // pc_adrs + 1 is 8-bit modulo, so 8'hFF wraps to 8'h00.
    assign nxt_adrs_d = br_take ? br_adrs : pc_adrs + 8'd1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            nxt_adrs_q  <= 8'h00;
            en_pc_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_adrs_q  <= 8'h00;
            instr_q     <= 8'h00;
            instr_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_fetch && !err_q) begin
                        state_q    <= REQ;
                        mem_adrs_q <= pc_adrs;
                        mem_req_q  <= 1'b1;
                        wait_q     <= 4'd0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        instr_q     <= mem_data;
                        instr_vld_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        state_q     <= HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_q    <= wait_q + 4'd1;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (instr_take) begin
                        instr_vld_q <= 1'b0;
                        nxt_adrs_q  <= nxt_adrs_d;
                        en_pc_q     <= 1'b1;
                        state_q     <= UPD;
                    end
                end
                UPD: begin
                    en_pc_q <= 1'b0;
                    if (en_fetch) begin
                        // The pc register loads nxt_adrs on this same edge, so
                        // nxt_adrs_q is the updated pc value.
                        state_q    <= REQ;
                        mem_adrs_q <= nxt_adrs_q;
                        mem_req_q  <= 1'b1;
                        wait_q     <= 4'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign nxt_adrs  = nxt_adrs_q;
    assign en_pc     = en_pc_q;
    assign mem_req   = mem_req_q;
    assign mem_adrs  = mem_adrs_q;
    assign instr     = instr_q;
    assign instr_vld = instr_vld_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural pc register in the loop.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       en_fetch;
    logic [7:0] pc_adrs;
    logic [7:0] nxt_adrs;
    logic       en_pc;
    logic       mem_req;
    logic [7:0] mem_adrs;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] instr;
    logic       instr_vld;
    logic       instr_take;
    logic       br_take;
    logic [7:0] br_adrs;
    logic       err;

    logic       pc_set;
    logic [7:0] pc_val;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .en_fetch   (en_fetch),
        .pc_adrs    (pc_adrs),
        .nxt_adrs   (nxt_adrs),
        .en_pc      (en_pc),
        .mem_req    (mem_req),
        .mem_adrs   (mem_adrs),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .instr      (instr),
        .instr_vld  (instr_vld),
        .instr_take (instr_take),
        .br_take    (br_take),
        .br_adrs    (br_adrs),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_set)
            pc_adrs <= pc_val;
        else if (en_pc)
            pc_adrs <= nxt_adrs;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b0; en_fetch = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
        instr_take = 1'b0; br_take = 1'b0; br_adrs = 8'h00;
        pc_set = 1'b1; pc_val = 8'h10; pc_adrs = 8'h00;
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_en_pc", en_pc, 0);
        chk("rst_vld", instr_vld, 0);
        chk("rst_err", err, 0);
        chk("rst_instr", instr, 8'h00);
        chk("rst_mem_adrs", mem_adrs, 8'h00);
        chk("rst_nxt", nxt_adrs, 8'h00);
        pc_set = 1'b0;
        clr = 1'b1;
        step();
        chk("idle_no_req", mem_req, 0);

        // Sequential fetch at 8'h10, ack in first REQ cycle, immediate take
        en_fetch = 1'b1;
        step();
        chk("seq_req", mem_req, 1);
        chk("seq_adrs", mem_adrs, 8'h10);
        mem_ack = 1'b1; mem_data = 8'hA5; instr_take = 1'b1;
        step();
        chk("seq_instr", instr, 8'hA5);
        chk("seq_vld", instr_vld, 1);
        chk("seq_req_drop", mem_req, 0);
        mem_ack = 1'b0;
        step();
        chk("seq_en_pc", en_pc, 1);
        chk("seq_nxt", nxt_adrs, 8'h11);
        chk("seq_vld_clr", instr_vld, 0);
        instr_take = 1'b0;
        step();
        chk("seq_en_pc_off", en_pc, 0);
        chk("seq_req2", mem_req, 1);
        chk("seq_adrs2", mem_adrs, 8'h11);
        chk("seq_nxt_hold", nxt_adrs, 8'h11);

        // Branch to 8'h40
        mem_ack = 1'b1; mem_data = 8'h3C; instr_take = 1'b1; br_take = 1'b1; br_adrs = 8'h40;
        step();
        chk("br_instr", instr, 8'h3C);
        mem_ack = 1'b0;
        step();
        chk("br_en_pc", en_pc, 1);
        chk("br_nxt", nxt_adrs, 8'h40);
        instr_take = 1'b0; br_take = 1'b0;
        step();
        chk("br_en_pc_1cyc", en_pc, 0);
        chk("br_adrs_req", mem_adrs, 8'h40);

        // br_take without instr_take is ignored; en_fetch low ends in IDLE
        mem_ack = 1'b1; mem_data = 8'h77; br_take = 1'b1; br_adrs = 8'h99;
        step();
        mem_ack = 1'b0;
        step();
        chk("brnt_vld", instr_vld, 1);
        chk("brnt_no_en_pc", en_pc, 0);
        instr_take = 1'b1; br_take = 1'b0; en_fetch = 1'b0;
        step();
        chk("brnt_nxt", nxt_adrs, 8'h41);
        instr_take = 1'b0;
        step();
        chk("stop_idle_req", mem_req, 0);
        step();
        chk("stop_idle_req2", mem_req, 0);

        // Wrap from 8'hFF; en_fetch drop during REQ does not abort
        pc_set = 1'b1; pc_val = 8'hFF;
        step();
        pc_set = 1'b0; en_fetch = 1'b1;
        step();
        chk("wrap_adrs", mem_adrs, 8'hFF);
        en_fetch = 1'b0;
        step();
        chk("noabort_req", mem_req, 1);
        mem_ack = 1'b1; mem_data = 8'h12; instr_take = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("wrap_nxt", nxt_adrs, 8'h00);
        chk("wrap_en_pc", en_pc, 1);
        instr_take = 1'b0;
        step();
        chk("wrap_idle", mem_req, 0);
        chk("wrap_nxt_hold", nxt_adrs, 8'h00);

        // Backpressure: instr held for 10 cycles, then async reset
        en_fetch = 1'b1;
        step();
        chk("bp_adrs", mem_adrs, 8'h00);
        mem_ack = 1'b1; mem_data = 8'h5A;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_vld", instr_vld, 1);
            chk("bp_instr", instr, 8'h5A);
            chk("bp_no_en_pc", en_pc, 0);
        end
        #2 clr = 1'b0;
        #1;
        chk("bp_rst_vld", instr_vld, 0);
        chk("bp_rst_req", mem_req, 0);
        chk("bp_rst_instr", instr, 8'h00);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("rel_no_early_req", mem_req, 0);

        // Reset mid-REQ
        @(negedge clk);
        chk("rel_req_first_edge", mem_req, 1);
        #2 clr = 1'b0;
        #1;
        chk("midreq_rst_req", mem_req, 0);
        chk("midreq_rst_adrs", mem_adrs, 8'h00);
        @(negedge clk);
        clr = 1'b1;

        // Reset mid-UPD
        step();
        mem_ack = 1'b1; mem_data = 8'hC3; instr_take = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("midupd_en_pc", en_pc, 1);
        #2 clr = 1'b0;
        #1;
        chk("midupd_rst_en_pc", en_pc, 0);
        chk("midupd_rst_nxt", nxt_adrs, 8'h00);
        @(negedge clk);
        instr_take = 1'b0;
        clr = 1'b1;

        // Timeout: 15 REQ cycles without ack
        step();
        chk("to_req_c1", mem_req, 1);
        repeat (13) step();
        chk("to_req_c14", mem_req, 1);
        step();
        chk("to_req_c15", mem_req, 1);
        chk("to_err_c15", err, 0);
        step();
        chk("to_req_drop", mem_req, 0);
        chk("to_err", err, 1);
        mem_ack = 1'b1; mem_data = 8'hEE;
        repeat (5) step();
        chk("to_blocked", mem_req, 0);
        chk("to_ack_ignored", instr, 8'h00);
        chk("to_err_sticky", err, 1);
        mem_ack = 1'b0;
        #2 clr = 1'b0;
        #1;
        chk("to_err_clr", err, 0);
        @(negedge clk);
        clr = 1'b1;
        step();
        chk("to_restart", mem_req, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach the end");
        $fatal(1);
    end

endmodule
